receptor_registrador: RTL and testbench

Serial-in / parallel-out receiver for the shift-register chain. Takes the bit stream produced when the parallel-load shift register is clocked in shift mode, reassembles it MSB-first into a WIDTH-bit word, and presents the word with a one-cycle valid pulse. It also tracks a sticky OR of all received data bits, matching the chain's OR-accumulate path, so downstream logic can test "any bit set" without decoding the word.

---
 rtl/receptor_registrador.sv | 132 +++++++++++++
 tb/tb_receptor_registrador.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/receptor_registrador.sv
// receptor_registrador: serial-in / parallel-out receiver for the shift-register chain.
// Reassembles an MSB-first bit stream into a WIDTH-bit word and reports it with a
// one-cycle dado_valido pulse. It also keeps a sticky OR of the frame's data bits.
// Optional feature: define RECEPTOR_PARIDADE_EN to require a trailing even-parity bit.
module receptor_registrador #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic             bit_valido,
  input  logic             bit_serial,
  output logic [WIDTH-1:0] dado_paralelo,
  output logic             dado_valido,
  output logic             ocupado,
  output logic             ou_acumulado,
  output logic             erro
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

`ifdef RECEPTOR_PARIDADE_EN
  typedef enum logic [1:0] {OCIOSO, RECEBENDO, PARIDADE} estado_t;
`else
  typedef enum logic [1:0] {OCIOSO, RECEBENDO} estado_t;
`endif

  estado_t          r_estado, w_estado_prox;
  logic [WIDTH-1:0] r_buffer, w_buffer_prox, w_buffer_desl;
  logic [CW-1:0]    r_cont, w_cont_prox;
  logic             r_ou, w_ou_prox;
  logic [WIDTH-1:0] r_dado, w_dado_prox;
  logic             r_ou_acum, w_ou_acum_prox;
  logic             r_valido, w_valido_prox;
  logic             r_erro, w_erro_prox;
  logic             r_ocupado;

  assign w_buffer_desl = {r_buffer[WIDTH-2:0], bit_serial};

  // Next-state and next-datapath decode; inicio takes priority over any bit this cycle.
  always_comb begin
    w_estado_prox  = r_estado;
    w_buffer_prox  = r_buffer;
    w_cont_prox    = r_cont;
    w_ou_prox      = r_ou;
    w_dado_prox    = r_dado;
    w_ou_acum_prox = r_ou_acum;
    w_valido_prox  = 1'b0;
    w_erro_prox    = 1'b0;
    if (inicio) begin
      // A start strobe inside a frame discards the partial frame and restarts it.
      w_erro_prox   = (r_estado != OCIOSO);
      w_estado_prox = RECEBENDO;
      w_buffer_prox = '0;
      w_cont_prox   = '0;
      w_ou_prox     = 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          w_estado_prox = OCIOSO;
        end
        RECEBENDO: begin
          if (bit_valido) begin
            w_buffer_prox = w_buffer_desl;
            w_cont_prox   = r_cont + CW'(1);
            w_ou_prox     = r_ou | bit_serial;
            if (r_cont == ULTIMO) begin
`ifdef RECEPTOR_PARIDADE_EN
              w_estado_prox = PARIDADE;
`else
              w_dado_prox    = w_buffer_desl;
              w_ou_acum_prox = r_ou | bit_serial;
              w_valido_prox  = 1'b1;
              w_estado_prox  = OCIOSO;
`endif
            end
          end
        end
`ifdef RECEPTOR_PARIDADE_EN
        PARIDADE: begin
          if (bit_valido) begin
            w_estado_prox = OCIOSO;
            if (bit_serial == (^r_buffer)) begin
              w_dado_prox    = r_buffer;
              w_ou_acum_prox = r_ou;
              w_valido_prox  = 1'b1;
            end else begin
              w_erro_prox = 1'b1;
            end
          end
        end
`endif
        default: begin
          w_estado_prox = OCIOSO;
        end
      endcase
    end
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado  <= OCIOSO;
      r_buffer  <= '0;
      r_cont    <= '0;
      r_ou      <= 1'b0;
      r_dado    <= '0;
      r_ou_acum <= 1'b0;
      r_valido  <= 1'b0;
      r_erro    <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_buffer  <= w_buffer_prox;
      r_cont    <= w_cont_prox;
      r_ou      <= w_ou_prox;
      r_dado    <= w_dado_prox;
      r_ou_acum <= w_ou_acum_prox;
      r_valido  <= w_valido_prox;
      r_erro    <= w_erro_prox;
      r_ocupado <= (w_estado_prox != OCIOSO);
    end
  end

  assign dado_paralelo = r_dado;
  assign dado_valido   = r_valido;
  assign ocupado       = r_ocupado;
  assign ou_acumulado  = r_ou_acum;
  assign erro          = r_erro;

endmodule

// File: tb/tb_receptor_registrador.sv
// Bench for receptor_registrador: directed frames from the test plan followed by
// random traffic, every cycle compared against a frame-level reference model.
module tb_receptor_registrador;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         inicio;
  logic         bit_valido;
  logic         bit_serial;
  logic [W-1:0] dado_paralelo;
  logic         dado_valido;
  logic         ocupado;
  logic         ou_acumulado;
  logic         erro;

  receptor_registrador #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .inicio       (inicio),
    .bit_valido   (bit_valido),
    .bit_serial   (bit_serial),
    .dado_paralelo(dado_paralelo),
    .dado_valido  (dado_valido),
    .ocupado      (ocupado),
    .ou_acumulado (ou_acumulado),
    .erro         (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: a frame is just the list of bits received so far.
  bit           m_ativo;
  bit           m_bits[$];
  logic [W-1:0] exp_dado;
  logic         exp_valido;
  logic         exp_ou;
  logic         exp_erro;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_complete();
    logic [W-1:0] word;
    word = '0;
    for (int i = 0; i < W; i++) word[W-1-i] = m_bits[i];
    exp_dado   = word;
    exp_ou     = (word != 0);
    exp_valido = 1'b1;
  endtask

  task automatic model(input logic r, input logic ini, input logic bv, input logic b);
    int ones;
    exp_valido = 1'b0;
    exp_erro   = 1'b0;
    if (r) begin
      m_ativo = 1'b0;
      m_bits.delete();
      exp_dado = '0;
      exp_ou   = 1'b0;
    end else if (ini) begin
      exp_erro = m_ativo;
      m_ativo  = 1'b1;
      m_bits.delete();
    end else if (m_ativo && bv) begin
      m_bits.push_back(b);
`ifdef RECEPTOR_PARIDADE_EN
      if (m_bits.size() == W + 1) begin
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(m_bits[i]);
        if (int'(m_bits[W]) == ones % 2) model_complete();
        else exp_erro = 1'b1;
        m_ativo = 1'b0;
      end
`else
      ones = 0;
      if (m_bits.size() == W) begin
        model_complete();
        m_ativo = 1'b0;
      end
`endif
    end
  endtask

  task automatic step(input logic r, input logic ini, input logic bv, input logic b);
    rst        = r;
    inicio     = ini;
    bit_valido = bv;
    bit_serial = b;
    @(posedge clk);
    model(r, ini, bv, b);
    #1;
    check("dado_paralelo", 32'(dado_paralelo), 32'(exp_dado));
    check("dado_valido", 32'(dado_valido), 32'(exp_valido));
    check("ocupado", 32'(ocupado), 32'(m_ativo));
    check("ou_acumulado", 32'(ou_acumulado), 32'(exp_ou));
    check("erro", 32'(erro), 32'(exp_erro));
  endtask

  // Start strobe, WIDTH data bits MSB first (gap idle cycles between bits), parity if enabled.
  task automatic send_frame(input logic [W-1:0] word, input int gap);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) begin
      if (i != W - 1)
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
      step(1'b0, 1'b0, 1'b1, word[i]);
    end
`ifdef RECEPTOR_PARIDADE_EN
    step(1'b0, 1'b0, 1'b1, ^word);
`endif
  endtask

  initial begin
    logic [W-1:0] w5a;
    int r;
    rst = 1'b0; inicio = 1'b0; bit_valido = 1'b0; bit_serial = 1'b0;
    m_ativo = 1'b0; exp_dado = '0; exp_valido = 1'b0; exp_ou = 1'b0; exp_erro = 1'b0;
    @(negedge clk);

    // Reset for two cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_dado", 32'(dado_paralelo), 32'h0);

    // Basic back-to-back frame, then one idle cycle to see the pulse drop.
    send_frame(8'hB2, 0);
    check("b2_word", 32'(dado_paralelo), 32'hB2);
    check("b2_valid", 32'(dado_valido), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("b2_valid_drop", 32'(dado_valido), 32'h0);

    // Gapped all-zero frame.
    send_frame(8'h00, 3);
    check("zero_word", 32'(dado_paralelo), 32'h0);
    check("zero_ou", 32'(ou_acumulado), 32'h0);

    // Abort: five bits, restart, then 0x5A.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom));
    w5a = 8'h5A;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("abort_erro", 32'(erro), 32'h1);
    for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, w5a[i]);
`ifdef RECEPTOR_PARIDADE_EN
    step(1'b0, 1'b0, 1'b1, ^w5a);
`endif
    check("5a_word", 32'(dado_paralelo), 32'h5A);

    // New frame starts in the same cycle dado_valido is high; reset after 4 bits.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_mid_erro", 32'(erro), 32'h0);
    check("rst_mid_ocupado", 32'(ocupado), 32'h0);
    send_frame(8'hFF, 1);
    check("ff_word", 32'(dado_paralelo), 32'hFF);

    // inicio together with the last data bit: the frame is aborted.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W - 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("last_bit_abort_valid", 32'(dado_valido), 32'h0);
    check("last_bit_abort_erro", 32'(erro), 32'h1);
    send_frame(8'h3C, 0);

`ifdef RECEPTOR_PARIDADE_EN
    // Good parity, then bad parity on the same word.
    send_frame(8'hB2, 0);
    check("par_ok_word", 32'(dado_paralelo), 32'hB2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    w5a = 8'hB2;
    for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, w5a[i]);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("par_bad_erro", 32'(erro), 32'h1);
    check("par_bad_valid", 32'(dado_valido), 32'h0);
    check("par_bad_hold", 32'(dado_paralelo), 32'hB2);
`endif

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 199));
      step(1'(r < 2),
           1'((r >= 2 && r < 8) || (!m_ativo && r < 60)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
